// File: rtl/gearbox_tx.sv
// Per-lane 66b-to-64b transmit gearbox: 32 blocks in, 33 words out per period.
// Optional GEARBOX_TX_SEQ_DBG_EN exposes the shared sequence counter on seq_o.
module gearbox_tx #(
  parameter int LANE_N  = 4,
  parameter int HEAD_W  = 2,
  parameter int DATA_W  = 64,
  parameter int BLOCK_W = HEAD_W + DATA_W
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic [LANE_N*HEAD_W-1:0]   head_i,
  input  logic [LANE_N*DATA_W-1:0]   data_i,
  output logic                       ready_o,
  output logic [LANE_N*DATA_W-1:0]   data_o
`ifdef GEARBOX_TX_SEQ_DBG_EN
  ,
  output logic [5:0]                 seq_o
`endif
);

  localparam int          WIDE_W    = 2 * DATA_W;
  localparam logic [5:0]  SEQ_STALL = 6'(DATA_W / HEAD_W);

  logic [5:0] seq_reg;
  logic [5:0] seq_next;
  logic       stall;
  logic [6:0] shamt;

  assign stall   = (seq_reg == SEQ_STALL);
  assign shamt   = {seq_reg, 1'b0};
  assign ready_o = !nreset && !stall;

  always_comb begin
    seq_next = seq_reg + 6'd1;
    if (stall) begin
      seq_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      seq_reg <= '0;
    end else begin
      seq_reg <= seq_next;
    end
  end

`ifdef GEARBOX_TX_SEQ_DBG_EN
  assign seq_o = seq_reg;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < LANE_N; gi++) begin : g_lane
      logic [DATA_W-1:0] res_reg;
      logic [DATA_W-1:0] res_next;
      logic [DATA_W-1:0] word_reg;
      logic [DATA_W-1:0] word_next;
      logic [WIDE_W-1:0] t_full;

      // Residual bits above 2*seq are always zero, so a plain OR splices the new block in.
      always_comb begin
        t_full = ({{(WIDE_W-BLOCK_W){1'b0}},
                   data_i[gi*DATA_W +: DATA_W],
                   head_i[gi*HEAD_W +: HEAD_W]} << shamt)
               | {{(WIDE_W-DATA_W){1'b0}}, res_reg};
        word_next = t_full[DATA_W-1:0];
        res_next  = t_full[WIDE_W-1:DATA_W];
        if (stall) begin
          word_next = res_reg;
          res_next  = '0;
        end
      end

      always_ff @(posedge clk) begin
        if (nreset) begin
          res_reg  <= '0;
          word_reg <= '0;
        end else begin
          res_reg  <= res_next;
          word_reg <= word_next;
        end
      end

      assign data_o[gi*DATA_W +: DATA_W] = word_reg;
    end
  endgenerate

endmodule

// File: tb/tb_gearbox_tx.sv
// Scoreboard bench for gearbox_tx: a per-lane serial bit-stream model predicts each output word.
module tb_gearbox_tx;
  localparam int LANE_N = 4;
  localparam int HEAD_W = 2;
  localparam int DATA_W = 64;

  logic                      clk = 1'b0;
  logic                      nreset = 1'b1;
  logic [LANE_N*HEAD_W-1:0]  head_i = '0;
  logic [LANE_N*DATA_W-1:0]  data_i = '0;
  logic                      ready_o;
  logic [LANE_N*DATA_W-1:0]  data_o;
`ifdef GEARBOX_TX_SEQ_DBG_EN
  logic [5:0]                seq_o;
`endif

  gearbox_tx #(.LANE_N(LANE_N), .HEAD_W(HEAD_W), .DATA_W(DATA_W)) dut (
    .clk    (clk),
    .nreset (nreset),
    .head_i (head_i),
    .data_i (data_i),
    .ready_o(ready_o),
    .data_o (data_o)
`ifdef GEARBOX_TX_SEQ_DBG_EN
    ,
    .seq_o  (seq_o)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [LANE_N*DATA_W-1:0] exp_q[$];
  bit started = 0;

  // Model: each lane is a FIFO of serial bits held in a wide vector, bit 0 sent first.
  logic [191:0] bitbuf [LANE_N];
  int           bitcnt = 0;
  int           rel    = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // One clock of stimulus: drive at the falling edge, check ready_o, queue the expected word.
  task automatic step(input logic rst, input logic [7:0] h, input logic [255:0] d);
    logic [255:0] expw;
    logic         exp_ready;
    @(negedge clk);
    nreset = rst;
    head_i = h;
    data_i = d;
    #1;
    exp_ready = !rst && ((rel % 33) != 32);
    chk("ready_o", {255'b0, ready_o}, {255'b0, exp_ready});
`ifdef GEARBOX_TX_SEQ_DBG_EN
    if (!rst) chk("seq_o", {250'b0, seq_o}, 256'(rel % 33));
`endif
    expw = '0;
    if (rst) begin
      for (int l = 0; l < LANE_N; l++) bitbuf[l] = '0;
      bitcnt = 0;
      rel    = 0;
    end else begin
      if (exp_ready) begin
        for (int l = 0; l < LANE_N; l++)
          bitbuf[l] = bitbuf[l] | ({126'b0, d[l*DATA_W +: DATA_W], h[l*HEAD_W +: HEAD_W]} << bitcnt);
        bitcnt += 66;
      end
      for (int l = 0; l < LANE_N; l++) begin
        expw[l*DATA_W +: DATA_W] = bitbuf[l][63:0];
        bitbuf[l] = bitbuf[l] >> 64;
      end
      bitcnt -= 64;
      rel++;
    end
    exp_q.push_back(expw);
    started = 1;
  endtask

  task automatic check_lane0(input string nm, input logic [63:0] exp);
    @(posedge clk);
    #2;
    chk(nm, {192'b0, data_o[63:0]}, {192'b0, exp});
    $display("directed %s: lane0 data_o=%h", nm, data_o[63:0]);
  endtask

  // Monitor: compares data_o after every rising edge against the oldest queued expectation.
  initial begin
    logic [255:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("data_o", data_o, e);
      end else if (started) begin
        chk("scoreboard_underflow", 256'(exp_q.size()), 256'd1);
      end
    end
  end

  initial begin
    bit did_rst = 0;
    for (int l = 0; l < LANE_N; l++) bitbuf[l] = '0;

    for (int i = 0; i < 3; i++) step(1'b1, 8'h0, '0);

    // Single-bit header lands in bit 0 of the first word.
    step(1'b0, 8'b01, '0);
    check_lane0("head01_w0", 64'h0000_0000_0000_0001);
    step(1'b0, 8'h0, '0);
    check_lane0("head01_w1", 64'h0);

    for (int i = 0; i < 2; i++) step(1'b1, 8'h0, '0);
    step(1'b0, 8'b10, {192'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    check_lane0("ones_w0", 64'hFFFF_FFFF_FFFF_FFFE);
    step(1'b0, 8'h0, '0);
    check_lane0("ones_w1", 64'h3);

    // Distinct per-lane heads and data, run past one stall.
    step(1'b1, 8'h0, '0);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 8'b10_01_10_01, {64'd3, 64'd2, 64'd1, 64'd0});
      $display("lanes cycle %0d: data_o=%h", i, data_o);
    end

    // Random traffic; stall cycles see fresh random values that must be ignored.
    step(1'b1, 8'h0, '0);
    for (int i = 0; i < 20000; i++) begin
      if (!did_rst && i >= 5000 && (rel % 33) == 17) begin
        did_rst = 1;
        step(1'b1, 8'($urandom), rnd256());
        @(posedge clk);
        #2;
        chk("reset_data_o", data_o, '0);
        $display("mid-period reset: data_o=%h", data_o);
        step(1'b0, 8'b01, '0);
        check_lane0("after_reset_w0", 64'h1);
      end else begin
        step(1'b0, 8'($urandom), rnd256());
      end
      if ((i % 33) == 0) $display("random period %0d: errors=%0d checks=%0d", i / 33, errors, checks);
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 256'(exp_q.size()), 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
